codec_cmm_sad_acc_tree: RTL and testbench

//  Pipelined N-lane reduction tree with SAD front-end and multi-beat block accumulator.
//  Per beat: sums N lanes of A (SUM mode) or N lanes of |A-B| (SAD mode); accumulates beats sop..eop into one block result.

---
 rtl/codec_cmm_pkg.sv | 33 +++
 rtl/codec_cmm_tree_level.sv | 39 +++
 rtl/codec_cmm_sad_acc_tree.sv | 163 ++++++++++++++++
 tb/tb_codec_cmm_sad_acc_tree.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_cmm_pkg.sv
// Shared definitions for the cmm adder-tree family: mode encodings,
// accumulator states and width helpers used to size the reduction tree.
package codec_cmm_pkg;

  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_SAD = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_e;

  // Number of nodes after lvl halving steps (ceil each step), starting from n lanes.
  function automatic int tree_nodes(input int n, input int lvl);
    int k;
    k = n;
    for (int i = 0; i < lvl; i++) begin
      k = (k + 1) / 2;
    end
    return k;
  endfunction

  // Width of one beat sum: lane width plus one bit per tree level.
  function automatic int beat_width(input int dw, input int n);
    return dw + $clog2(n);
  endfunction

  // Width of the beat counter, able to hold max_beats itself.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/codec_cmm_tree_level.sv
// One registered reduction level: NIN inputs of W bits fold into
// ceil(NIN/2) outputs of W+1 bits. Node j adds input j and input j+NOUT;
// with an odd input count the middle input passes through unchanged.
module codec_cmm_tree_level #(
  parameter int NIN = 2,
  parameter int W   = 8,
  localparam int NOUT = (NIN + 1) / 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld_i,
  input  logic [NIN*W-1:0]      data_i,
  output logic [NOUT*(W+1)-1:0] data_o
);

  localparam int NPAIR = NIN / 2;

  logic [NOUT*(W+1)-1:0] data_d, data_q;

  for (genvar j = 0; j < NOUT; j++) begin : g_node
    if (j < NPAIR) begin : g_pair
      assign data_d[j*(W+1) +: W+1] = {1'b0, data_i[j*W +: W]} + {1'b0, data_i[(j+NOUT)*W +: W]};
    end else begin : g_pass
      assign data_d[j*(W+1) +: W+1] = {1'b0, data_i[j*W +: W]};
    end
  end

  // Level register: loads only on a valid beat, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (vld_i) begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/codec_cmm_sad_acc_tree.sv
// N-lane SUM/SAD reduction tree with a multi-beat block accumulator.
// Front-end stage, LV tree levels and one accumulator stage give a fixed
// latency of LV+2 cycles; no backpressure.
//
// state   | meaning
// IDLE    | no block open, waiting for a sop beat
// ACC     | block open, accumulating beats until eop
module codec_cmm_sad_acc_tree import codec_cmm_pkg::*; #(
  parameter int N         = 16,
  parameter int DW        = 8,
  parameter int MAX_BEATS = 16,
  localparam int LV = $clog2(N),
  localparam int SW = beat_width(DW, N),
  localparam int AW = cnt_width(MAX_BEATS),
  localparam int OW = SW + AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  input  logic          i_sop,
  input  logic          i_eop,
  input  logic          i_mode,
  input  logic [N*DW-1:0] i_a,
  input  logic [N*DW-1:0] i_b,
  input  logic          i_err_clr,
  output logic          o_vld,
  output logic [OW-1:0] o_sum,
  output logic [AW-1:0] o_beats,
  output logic          o_ovf,
  output logic          o_seq_err
);

  logic [N*DW-1:0] lane_d, lane_q;
  logic [LV:0]     vld_q, sop_q, eop_q;
  logic [SW-1:0]   beat;

  // Unsigned subtract both ways and pick the non-negative one for SAD.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [DW-1:0] a_k, b_k, d_ab, d_ba;
    assign a_k  = i_a[k*DW +: DW];
    assign b_k  = i_b[k*DW +: DW];
    assign d_ab = a_k - b_k;
    assign d_ba = b_k - a_k;
    assign lane_d[k*DW +: DW] = (i_mode == MODE_SAD) ? ((a_k >= b_k) ? d_ab : d_ba) : a_k;
  end

  // Front-end lane register, loaded only on valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else if (i_vld) begin
      lane_q <= lane_d;
    end
  end

  // Valid/sop/eop chain; bit L is the valid of data entering tree level L.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sop_q <= '0;
      eop_q <= '0;
    end else begin
      vld_q <= {vld_q[LV-1:0], i_vld};
      sop_q <= {sop_q[LV-1:0], i_vld & i_sop};
      eop_q <= {eop_q[LV-1:0], i_vld & i_eop};
    end
  end

  for (genvar L = 0; L < LV; L++) begin : g_lvl
    localparam int NIN = tree_nodes(N, L);
    localparam int W   = DW + L;
    logic [NIN*W-1:0]                      lvl_in;
    logic [tree_nodes(N, L+1)*(W+1)-1:0]   lvl_out;
    if (L == 0) begin : g_first
      assign lvl_in = lane_q;
    end else begin : g_next
      assign lvl_in = g_lvl[L-1].lvl_out;
    end
    codec_cmm_tree_level #(.NIN(NIN), .W(W)) u_lvl (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (vld_q[L]),
      .data_i (lvl_in),
      .data_o (lvl_out)
    );
  end

  assign beat = g_lvl[LV-1].lvl_out;

  acc_state_e    state_q, state_d;
  logic [OW-1:0] acc_q, acc_d, sum_q, sum_d;
  logic [AW-1:0] cnt_q, cnt_d, beats_q, beats_d;
  logic          ovf_q, ovf_d, seq_q, seq_d, out_vld_q, out_vld_d;
  logic          ovf_set, seq_set;
  logic [OW-1:0] beat_ext;

  assign beat_ext = {{AW{1'b0}}, beat};

  // Accumulator FSM: open/extend/close blocks on tree-output beats.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    beats_d   = beats_q;
    out_vld_d = 1'b0;
    ovf_set   = 1'b0;
    seq_set   = 1'b0;
    if (vld_q[LV]) begin
      if (sop_q[LV]) begin
        seq_set = (state_q == ST_ACC);
        acc_d   = beat_ext;
        cnt_d   = AW'(1);
        state_d = ST_ACC;
      end else if (state_q == ST_IDLE) begin
        seq_set = 1'b1;
      end else if (cnt_q == AW'(MAX_BEATS)) begin
        ovf_set = 1'b1;
      end else begin
        acc_d = acc_q + beat_ext;
        cnt_d = cnt_q + 1'b1;
      end
      if (eop_q[LV] && (state_d == ST_ACC)) begin
        out_vld_d = 1'b1;
        sum_d     = acc_d;
        beats_d   = cnt_d;
        state_d   = ST_IDLE;
      end
    end
    ovf_d = ovf_set | (ovf_q & ~i_err_clr);
    seq_d = seq_set | (seq_q & ~i_err_clr);
  end

  // Accumulator, result and sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      beats_q   <= '0;
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      beats_q   <= beats_d;
      out_vld_q <= out_vld_d;
      ovf_q     <= ovf_d;
      seq_q     <= seq_d;
    end
  end

  assign o_vld     = out_vld_q;
  assign o_sum     = sum_q;
  assign o_beats   = beats_q;
  assign o_ovf     = ovf_q;
  assign o_seq_err = seq_q;

endmodule

// File: tb/tb_codec_cmm_sad_acc_tree.sv
// Bench for the SUM/SAD accumulator tree. Three instances share one
// stimulus stream: 16 lanes/16 beats, 12 lanes/16 beats, 16 lanes/4 beats.
// A block-level model computes expected results from the beat data and is
// compared against every instance each cycle.
module tb_codec_cmm_sad_acc_tree;

  localparam int DLY = 5; // beat sampled -> reaches accumulator (LV+1, LV=4 for all)

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vld = 1'b0, sop = 1'b0, eop = 1'b0, mode = 1'b0, err_clr = 1'b0;
  logic [127:0] a = '0, b = '0;

  logic        d0_vld, d1_vld, d2_vld;
  logic [16:0] d0_sum, d1_sum;
  logic [14:0] d2_sum;
  logic [4:0]  d0_beats, d1_beats;
  logic [2:0]  d2_beats;
  logic        d0_ovf, d1_ovf, d2_ovf, d0_seq, d1_seq, d2_seq;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  codec_cmm_sad_acc_tree #(.N(16), .DW(8), .MAX_BEATS(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .i_vld(vld), .i_sop(sop), .i_eop(eop), .i_mode(mode),
    .i_a(a), .i_b(b), .i_err_clr(err_clr), .o_vld(d0_vld), .o_sum(d0_sum),
    .o_beats(d0_beats), .o_ovf(d0_ovf), .o_seq_err(d0_seq));

  codec_cmm_sad_acc_tree #(.N(12), .DW(8), .MAX_BEATS(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .i_vld(vld), .i_sop(sop), .i_eop(eop), .i_mode(mode),
    .i_a(a[95:0]), .i_b(b[95:0]), .i_err_clr(err_clr), .o_vld(d1_vld), .o_sum(d1_sum),
    .o_beats(d1_beats), .o_ovf(d1_ovf), .o_seq_err(d1_seq));

  codec_cmm_sad_acc_tree #(.N(16), .DW(8), .MAX_BEATS(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .i_vld(vld), .i_sop(sop), .i_eop(eop), .i_mode(mode),
    .i_a(a), .i_b(b), .i_err_clr(err_clr), .o_vld(d2_vld), .o_sum(d2_sum),
    .o_beats(d2_beats), .o_ovf(d2_ovf), .o_seq_err(d2_seq));

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit get_vld(input int d);
    case (d)
      0: return d0_vld;
      1: return d1_vld;
      default: return d2_vld;
    endcase
  endfunction

  function automatic longint get_sum(input int d);
    case (d)
      0: return longint'(d0_sum);
      1: return longint'(d1_sum);
      default: return longint'(d2_sum);
    endcase
  endfunction

  function automatic int get_beats(input int d);
    case (d)
      0: return int'(d0_beats);
      1: return int'(d1_beats);
      default: return int'(d2_beats);
    endcase
  endfunction

  function automatic bit get_ovf(input int d);
    case (d)
      0: return d0_ovf;
      1: return d1_ovf;
      default: return d2_ovf;
    endcase
  endfunction

  function automatic bit get_seq(input int d);
    case (d)
      0: return d0_seq;
      1: return d1_seq;
      default: return d2_seq;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    bit     vld;
    longint sum;
    int     beats;
    bit     ovf_set;
    bit     seq_set;
  } evt_t;

  int     NL[3] = '{16, 12, 16};
  int     MX[3] = '{16, 16, 4};
  evt_t   dl[3][DLY];
  bit     m_open[3];
  longint m_acc[3];
  int     m_cnt[3];
  bit     e_vld[3], e_ovf[3], e_seq[3];
  longint e_sum[3];
  int     e_beats[3];

  function automatic longint beat_sum(input int n, input bit md, input logic [127:0] aa,
                                      input logic [127:0] bb);
    longint s;
    int x, y;
    s = 0;
    for (int k = 0; k < n; k++) begin
      x = int'(aa[k*8 +: 8]);
      y = int'(bb[k*8 +: 8]);
      s += md ? ((x > y) ? x - y : y - x) : x;
    end
    return s;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < DLY; i++) begin
        dl[d][i].vld = 0; dl[d][i].sum = 0; dl[d][i].beats = 0;
        dl[d][i].ovf_set = 0; dl[d][i].seq_set = 0;
      end
      m_open[d] = 0; m_acc[d] = 0; m_cnt[d] = 0;
      e_vld[d] = 0; e_sum[d] = 0; e_beats[d] = 0; e_ovf[d] = 0; e_seq[d] = 0;
    end
  endtask

  // Compare every cycle, then advance the model by the beat about to be sampled.
  always @(negedge clk) begin
    evt_t cur, old;
    longint s;
    if (!rst_n) model_clear();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_vld", d), longint'(get_vld(d)), longint'(e_vld[d]));
      chk($sformatf("d%0d_sum", d), get_sum(d), e_sum[d]);
      chk($sformatf("d%0d_beats", d), longint'(get_beats(d)), longint'(e_beats[d]));
      chk($sformatf("d%0d_ovf", d), longint'(get_ovf(d)), longint'(e_ovf[d]));
      chk($sformatf("d%0d_seq_err", d), longint'(get_seq(d)), longint'(e_seq[d]));
    end
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        cur.vld = 0; cur.sum = 0; cur.beats = 0; cur.ovf_set = 0; cur.seq_set = 0;
        if (vld) begin
          s = beat_sum(NL[d], mode, a, b);
          if (sop) begin
            cur.seq_set = m_open[d];
            m_acc[d] = s; m_cnt[d] = 1; m_open[d] = 1;
          end else if (!m_open[d]) begin
            cur.seq_set = 1;
          end else if (m_cnt[d] == MX[d]) begin
            cur.ovf_set = 1;
          end else begin
            m_acc[d] += s; m_cnt[d]++;
          end
          if (eop && m_open[d]) begin
            cur.vld = 1; cur.sum = m_acc[d]; cur.beats = m_cnt[d];
            m_open[d] = 0;
          end
        end
        old = dl[d][DLY-1];
        for (int i = DLY-1; i > 0; i--) dl[d][i] = dl[d][i-1];
        dl[d][0] = cur;
        e_vld[d] = old.vld;
        if (old.vld) begin
          e_sum[d] = old.sum; e_beats[d] = old.beats;
        end
        e_ovf[d] = old.ovf_set | (e_ovf[d] & ~err_clr);
        e_seq[d] = old.seq_set | (e_seq[d] & ~err_clr);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input bit s, input bit e, input bit m,
                       input logic [127:0] aa, input logic [127:0] bb);
    @(posedge clk);
    #1;
    vld = v; sop = s; eop = e; mode = m; a = aa; b = bb; err_clr = 1'b0;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, '0);
  endtask

  task automatic wait_vld(input int d, input int maxc, output int lat);
    lat = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (get_vld(d)) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_vld_d%0d: got no o_vld in %0d cycles, expected a pulse", d, maxc);
    end
  endtask

  logic [127:0] ones, twos, threes, ff, ta, tb2;
  int lat, cnt;

  initial begin
    ones = {16{8'd1}};
    twos = {16{8'd2}};
    threes = {16{8'd3}};
    ff = {16{8'hFF}};
    ta = '0;
    tb2 = '0;
    for (int k = 0; k < 12; k++) begin
      ta[k*8 +: 8] = 8'(k);
      tb2[k*8 +: 8] = 8'(11 - k);
    end

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vld", longint'(d0_vld), 0);
    chk("rst_sum", longint'(d0_sum), 0);

    // T1: single beat, all lanes 255
    drive(1, 1, 1, 0, ff, '0);
    idle();
    wait_vld(0, 20, lat);
    chk("t1_latency", lat, 6);
    chk("t1_sum", longint'(d0_sum), 4080);
    chk("t1_beats", longint'(d0_beats), 1);
    chk("t1_sum_n12", longint'(d1_sum), 3060);

    // T2: 12 lanes, SAD of k vs 11-k
    drive(1, 1, 1, 1, ta, tb2);
    idle();
    wait_vld(1, 20, lat);
    chk("t2_latency", lat, 6);
    chk("t2_sum", longint'(d1_sum), 72);

    // T3: back-to-back blocks
    drive(1, 1, 0, 0, ones, '0);
    drive(1, 0, 0, 0, ones, '0);
    drive(1, 0, 0, 0, ones, '0);
    drive(1, 0, 1, 0, ones, '0);
    drive(1, 1, 0, 0, twos, '0);
    drive(1, 0, 1, 0, twos, '0);
    idle();
    wait_vld(0, 20, lat);
    chk("t3_sum1", longint'(d0_sum), 64);
    chk("t3_beats1", longint'(d0_beats), 4);
    @(negedge clk);
    chk("t3_gap_vld", longint'(d0_vld), 0);
    @(negedge clk);
    chk("t3_vld2", longint'(d0_vld), 1);
    chk("t3_sum2", longint'(d0_sum), 64);
    chk("t3_beats2", longint'(d0_beats), 2);

    // T4: 6-beat block against MAX_BEATS=4
    drive(1, 1, 0, 0, ones, '0);
    repeat (4) drive(1, 0, 0, 0, ones, '0);
    drive(1, 0, 1, 0, ones, '0);
    idle();
    wait_vld(2, 20, lat);
    chk("t4_sum", longint'(d2_sum), 64);
    chk("t4_beats", longint'(d2_beats), 4);
    chk("t4_ovf", longint'(d2_ovf), 1);
    chk("t4_sum_big", longint'(d0_sum), 96);
    chk("t4_ovf_big", longint'(d0_ovf), 0);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("t4_ovf_clr", longint'(d2_ovf), 0);

    // T5: orphan beat, then sop inside an open block
    drive(1, 0, 0, 0, ones, '0);
    drive(1, 1, 0, 0, ones, '0);
    drive(1, 0, 0, 0, ones, '0);
    drive(1, 1, 0, 0, threes, '0);
    drive(1, 0, 1, 0, threes, '0);
    idle();
    wait_vld(0, 20, lat);
    chk("t5_sum", longint'(d0_sum), 96);
    chk("t5_beats", longint'(d0_beats), 2);
    chk("t5_seq_err", longint'(d0_seq), 1);

    // T6: reset mid-block
    drive(1, 1, 0, 0, ones, '0);
    drive(1, 0, 0, 0, ones, '0);
    @(posedge clk); #1;
    rst_n = 1'b0; vld = 1'b0; sop = 1'b0; eop = 1'b0;
    @(negedge clk);
    chk("t6_rst_sum", longint'(d0_sum), 0);
    chk("t6_rst_seq", longint'(d0_seq), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (d0_vld) cnt++;
    end
    chk("t6_spurious_vld", cnt, 0);
    drive(1, 1, 1, 0, twos, '0);
    idle();
    wait_vld(0, 20, lat);
    chk("t6_sum", longint'(d0_sum), 32);
    chk("t6_beats", longint'(d0_beats), 1);

    // Random traffic including protocol violations and overflow
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1,
            {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 19) == 0) err_clr = 1'b1;
    end
    idle();
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
